// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit: FSM states, funct3 encodings,
// and the request legality checks used when a request is accepted.
package lsu_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STORE,
        S_RMW_RD,
        S_RMW_WR,
        S_RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // funct3[1:0] encodes access size for every legal load and store.
    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   return a[0];
            2'b10:   return a != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic lsu_illegal(input logic wr, input logic [2:0] f3);
        if (wr)
            return !(f3 == F3_B || f3 == F3_H || f3 == F3_W);
        return !(f3 == F3_B || f3 == F3_H || f3 == F3_W || f3 == F3_BU || f3 == F3_HU);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extracts/extends load data and merges sub-word
// store data into the word read back from memory.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] word_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] load_o,
    output logic [XLEN-1:0] store_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[8*addr_lo_i +: 8];
    assign half_sel = word_i[16*addr_lo_i[1] +: 16];

    always_comb begin
        load_o = word_i;
        case (funct3_i)
            F3_B:    load_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_H:    load_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_BU:   load_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_HU:   load_o = {{(XLEN-16){1'b0}}, half_sel};
            default: load_o = word_i;
        endcase
    end

    always_comb begin
        store_o = word_i;
        case (funct3_i)
            F3_B:    store_o[8*addr_lo_i +: 8]      = wdata_i[7:0];
            F3_H:    store_o[16*addr_lo_i[1] +: 16] = wdata_i[15:0];
            default: store_o = wdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store initiator: sub-word loads via extraction, sub-word stores
// via read-modify-write on a word-only data memory.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_write,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            mem_read,
    output logic            mem_write,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata
);

    if (XLEN != 32) begin : g_xlen_chk
        $error("load_store_unit supports XLEN=32 only");
    end

    lsu_state_e      state_q;
    logic [2:0]      f3_q;
    logic [XLEN-1:0] addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [XLEN-1:0] merged_q;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [XLEN-1:0] load_val;
    logic [XLEN-1:0] store_word;

    lsu_align #(.XLEN(XLEN)) u_align (
        .funct3_i  (f3_q),
        .addr_lo_i (addr_q[1:0]),
        .word_i    (mem_rdata),
        .wdata_i   (wdata_q),
        .load_o    (load_val),
        .store_o   (store_word)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            f3_q     <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            merged_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (req_valid) begin
                    f3_q    <= req_funct3;
                    addr_q  <= req_addr;
                    wdata_q <= req_wdata;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    if (lsu_illegal(req_write, req_funct3) ||
                        lsu_misaligned(req_funct3, req_addr[1:0])) begin
                        err_q   <= 1'b1;
                        state_q <= S_RESP;
                    end else if (!req_write)
                        state_q <= S_LOAD;
                    else if (req_funct3 == F3_W)
                        state_q <= S_STORE;
                    else
                        state_q <= S_RMW_RD;
                end
                S_LOAD: begin
                    rdata_q <= load_val;
                    state_q <= S_RESP;
                end
                S_STORE:  state_q <= S_RESP;
                S_RMW_RD: begin
                    merged_q <= store_word;
                    state_q  <= S_RMW_WR;
                end
                S_RMW_WR: state_q <= S_RESP;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    // Memory strobes decode straight from state so an async reset kills a write at once.
    assign req_ready  = (state_q == S_IDLE);
    assign resp_valid = (state_q == S_RESP);
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign mem_read   = (state_q == S_LOAD)  || (state_q == S_RMW_RD);
    assign mem_write  = (state_q == S_STORE) || (state_q == S_RMW_WR);
    assign mem_addr   = {addr_q[XLEN-1:2], 2'b00};
    assign mem_wdata  = (state_q == S_STORE)  ? wdata_q  :
                        (state_q == S_RMW_WR) ? merged_q : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized + directed bench for load_store_unit against an arithmetic reference model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_chk = 0;
    int n_fail = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_val = '0;

    bit          tr_rd [11];
    bit          tr_wr [11];
    logic [31:0] tr_wd [11];

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (pre_en) mem[pre_idx] <= pre_val;
        else if (mem_write) mem[mem_addr[7:2]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: expected response and memory effect from the access rules alone.
    function automatic void model(input bit w, input logic [2:0] f3, input logic [31:0] a,
                                  input logic [31:0] wd, output bit err,
                                  output logic [31:0] rd, output int lat);
        int unsigned size, sh;
        logic [31:0] word, v, mask;
        bit illegal;
        illegal = w ? (f3 > 3'd2) : !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size = 1 << f3[1:0];
        err = illegal || (a % size != 0);
        rd = 0;
        if (err) begin lat = 1; return; end
        word = ref_mem[a[7:2]];
        sh = (a % 4) * 8;
        if (!w) begin
            lat = 2;
            v = word >> sh;
            if (size == 1) begin
                v = v & 32'hFF;
                if (f3 == 3'd0 && v >= 128) v = v - 256;
            end else if (size == 2) begin
                v = v & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            end
            rd = v;
        end else if (size == 4) begin
            lat = 2;
            ref_mem[a[7:2]] = wd;
        end else begin
            lat = 3;
            mask = ((size == 1) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[a[7:2]] = (word & ~mask) | ((wd << sh) & mask);
        end
    endfunction

    task automatic do_op(input bit w, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output logic er,
                         output int lat, output bit anymem);
        @(negedge clk);
        chk("ready_idle", req_ready, 1);
        req_valid = 1; req_write = w; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk);
        lat = 0; anymem = 0; rd = 'x; er = 1'bx;
        for (int c = 0; c <= 10; c++) begin tr_rd[c] = 0; tr_wr[c] = 0; tr_wd[c] = 0; end
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (c == 1) req_valid = 0;
            tr_rd[c] = mem_read; tr_wr[c] = mem_write; tr_wd[c] = mem_wdata;
            anymem |= mem_read | mem_write;
            chk("rdwr_excl", {31'b0, mem_read & mem_write}, 0);
            if (resp_valid) begin
                lat = c; rd = resp_rdata; er = resp_err;
                break;
            end
        end
        if (lat == 0) chk("resp_timeout", 0, 1);
    endtask

    task automatic run(input bit w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er,
                       output int lat, output bit anymem);
        bit e_err; logic [31:0] e_rd; int e_lat;
        model(w, f3, a, wd, e_err, e_rd, e_lat);
        do_op(w, f3, a, wd, rd, er, lat, anymem);
        chk("lat", lat, e_lat);
        chk("err", {31'b0, er}, {31'b0, e_err});
        chk("rdata", rd, e_rd);
        if (e_err) chk("err_nomem", {31'b0, anymem}, 0);
    endtask

    initial begin
        logic [31:0] rd; logic er; int lat; bit am;
        logic [31:0] v;

        for (int i = 0; i < 64; i++) begin
            v = (i == 16) ? 32'h8899AABB : $urandom;
            ref_mem[i] = v;
            @(negedge clk);
            pre_en = 1; pre_idx = 6'(i); pre_val = v;
        end
        @(negedge clk);
        pre_en = 0;
        chk("rst_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        chk("rst_mem_rw", {30'b0, mem_read, mem_write}, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1;

        run(0, 3'b000, 32'h41, 0, rd, er, lat, am); chk("lb_41", rd, 32'hFFFFFFAA); chk("lb_lat", lat, 2);
        run(0, 3'b100, 32'h43, 0, rd, er, lat, am); chk("lbu_43", rd, 32'h00000088);
        run(0, 3'b001, 32'h42, 0, rd, er, lat, am); chk("lh_42", rd, 32'hFFFF8899);
        run(0, 3'b101, 32'h40, 0, rd, er, lat, am); chk("lhu_40", rd, 32'h0000AABB);
        run(0, 3'b010, 32'h40, 0, rd, er, lat, am); chk("lw_40", rd, 32'h8899AABB);

        run(1, 3'b000, 32'h42, 32'h12345677, rd, er, lat, am);
        chk("sb_c1_rd", {31'b0, tr_rd[1]}, 1);
        chk("sb_c2_wr", {31'b0, tr_wr[2]}, 1);
        chk("sb_c2_wd", tr_wd[2], 32'h8877AABB);
        chk("sb_lat", lat, 3);
        chk("sb_rdata", rd, 0);
        run(1, 3'b001, 32'h40, 32'h0000CAFE, rd, er, lat, am);
        @(negedge clk);
        chk("sh_mem", mem[16], 32'h8877CAFE);

        run(0, 3'b010, 32'h41, 0, rd, er, lat, am);
        chk("lw_mis", {er, 31'(lat), am}, {1'b1, 31'd1, 1'b0});
        run(1, 3'b001, 32'h43, 32'hFFFF, rd, er, lat, am);
        chk("sh_mis", {er, 31'(lat), am}, {1'b1, 31'd1, 1'b0});
        run(1, 3'b101, 32'h40, 32'hFFFF, rd, er, lat, am);
        chk("st_ill", {er, 31'(lat), am}, {1'b1, 31'd1, 1'b0});
        chk("st_ill_rd", rd, 0);

        // Two loads with req_valid held high throughout.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_funct3 = 3'b010; req_addr = 32'h40;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) begin req_funct3 = 3'b000; req_addr = 32'h41; end
            chk($sformatf("b2b_ready_c%0d", c), req_ready, (c == 3) ? 1 : 0);
            chk($sformatf("b2b_resp_c%0d", c), resp_valid, (c == 2 || c == 5) ? 1 : 0);
            if (c == 2) chk("b2b_rd1", resp_rdata, ref_mem[16]);
            if (c == 4) req_valid = 0;
            if (c == 5) chk("b2b_rd2", resp_rdata, 32'hFFFFFFCA);
        end

        for (int n = 0; n < 80; n++) begin
            logic [2:0] f3; logic [31:0] a; bit w;
            w  = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom_range(0, 255);
            if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << f3[1:0]) - 1);
            run(w, f3, a, $urandom, rd, er, lat, am);
        end
        @(negedge clk);
        for (int i = 0; i < 64; i++) chk($sformatf("mem_%0d", i), mem[i], ref_mem[i]);

        // Reset during the write phase of a read-modify-write.
        @(negedge clk);
        req_valid = 1; req_write = 1; req_funct3 = 3'b000; req_addr = 32'h81; req_wdata = $urandom;
        @(posedge clk);
        @(negedge clk);
        req_valid = 0;
        chk("rst_rmw_c1_rd", mem_read, 1);
        @(negedge clk);
        chk("rst_rmw_c2_wr", mem_write, 1);
        #2 rst_n = 0;
        #1;
        chk("rst_mid_wr", mem_write, 0);
        chk("rst_mid_ready", req_ready, 1);
        chk("rst_mid_resp", resp_valid, 0);
        @(negedge clk);
        chk("rst_mid_mem", mem[32], ref_mem[32]);
        rst_n = 1;
        run(0, 3'b010, 32'h80, 0, rd, er, lat, am);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
